// File: rtl/rca_modport_if.sv
// rtl/rca_modport_if.sv - operand/result bundle for the registered ripple-carry adder
interface rca_modport_if #(
  parameter int N = 2
);
  logic         in_valid;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic [N-1:0] SUM;
  logic         Cout;
  logic         OVF;
  logic         out_valid;

  // Producer side: drives operands, observes results.
  modport master (
    output in_valid, A, B, Cin,
    input  SUM, Cout, OVF, out_valid
  );

  // Adder side: consumes operands, drives registered results.
  modport slave (
    input  in_valid, A, B, Cin,
    output SUM, Cout, OVF, out_valid
  );
endinterface

// File: rtl/rca_modport.sv
// rtl/rca_modport.sv - registered N-bit ripple-carry adder; RCA_INPUT_REG_EN adds an input register stage
module rca_modport #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  rca_modport_if.slave bus
);

  logic [N-1:0] w_a;
  logic [N-1:0] w_b;
  logic         w_cin;
  logic         w_in_valid;

`ifdef RCA_INPUT_REG_EN
  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic         r_cin;
  logic         r_in_valid;

  // Input stage: operands are captured every cycle so throughput stays one per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_cin      <= 1'b0;
      r_in_valid <= 1'b0;
    end else begin
      r_a        <= bus.A;
      r_b        <= bus.B;
      r_cin      <= bus.Cin;
      r_in_valid <= bus.in_valid;
    end
  end

  assign w_a        = r_a;
  assign w_b        = r_b;
  assign w_cin      = r_cin;
  assign w_in_valid = r_in_valid;
`else
  assign w_a        = bus.A;
  assign w_b        = bus.B;
  assign w_cin      = bus.Cin;
  assign w_in_valid = bus.in_valid;
`endif

  // w_c[i] is the carry into cell i; w_c[N] is the carry out of the MSB cell.
  logic [N:0]   w_c;
  logic [N-1:0] w_s;

  // Ripple chain of one-bit full adders, Cin entering cell 0.
  always_comb begin
    w_c    = '0;
    w_s    = '0;
    w_c[0] = w_cin;
    for (int i = 0; i < N; i++) begin
      w_s[i]   = w_a[i] ^ w_b[i] ^ w_c[i];
      w_c[i+1] = (w_a[i] & w_b[i]) | (w_a[i] & w_c[i]) | (w_b[i] & w_c[i]);
    end
  end

  logic [N-1:0] r_sum;
  logic         r_cout;
  logic         r_ovf;
  logic         r_out_valid;

  // Result register: loads on a qualified operand, otherwise holds the last result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_in_valid;
      if (w_in_valid) begin
        r_sum  <= w_s;
        r_cout <= w_c[N];
        r_ovf  <= w_c[N-1] ^ w_c[N];
      end
    end
  end

  assign bus.SUM       = r_sum;
  assign bus.Cout      = r_cout;
  assign bus.OVF       = r_ovf;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_rca_modport.sv
// tb/tb_rca_modport.sv - self-checking bench for rca_modport at N=2 and N=8
module tb_rca_modport;

`ifdef RCA_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rca_modport_if #(.N(2)) bif2 ();
  rca_modport_if #(.N(8)) bif8 ();

  rca_modport #(.N(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bif2));
  rca_modport #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bif8));

  int n_vec = 0;
  int n_bad = 0;
  int pulses = 0;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic       cin;
    logic [1:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic       v2;
    logic [1:0] s2;
    logic       c2;
    logic       o2;
    logic       v8;
    logic [7:0] s8;
    logic       c8;
    logic       o8;
  } exp_t;

  exp_t exp_q[$];

  // Hold state of the reference model (last accepted result per width).
  logic [1:0] h2_s;
  logic       h2_c, h2_o;
  logic [7:0] h8_s;
  logic       h8_c, h8_o;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Arithmetic reference: returns {ovf, cout, sum[7:0]} for width n.
  function automatic logic [9:0] model(input int n, input logic [7:0] a, input logic [7:0] b,
                                       input logic cin);
    int u, sa, sb, sr, lim;
    logic [9:0] r;
    u   = int'(a) + int'(b) + int'(cin);
    lim = 1 << (n - 1);
    sa  = (int'(a) >= lim) ? int'(a) - (1 << n) : int'(a);
    sb  = (int'(b) >= lim) ? int'(b) - (1 << n) : int'(b);
    sr  = sa + sb + int'(cin);
    r        = '0;
    r[7:0]   = 8'(u & ((1 << n) - 1));
    r[8]     = ((u >> n) & 1) != 0;
    r[9]     = (sr > lim - 1) || (sr < -lim);
    return r;
  endfunction

  task automatic idle_all();
    bif2.in_valid = 1'b0; bif2.A = '0; bif2.B = '0; bif2.Cin = 1'b0;
    bif8.in_valid = 1'b0; bif8.A = '0; bif8.B = '0; bif8.Cin = 1'b0;
  endtask

  // One streaming cycle on both adders, scored against the model after LAT cycles.
  task automatic step(input logic v2, input logic [1:0] a2, input logic [1:0] b2, input logic c2,
                      input logic v8, input logic [7:0] a8, input logic [7:0] b8, input logic c8);
    exp_t e;
    logic [9:0] m;
    bif2.in_valid = v2; bif2.A = a2; bif2.B = b2; bif2.Cin = c2;
    bif8.in_valid = v8; bif8.A = a8; bif8.B = b8; bif8.Cin = c8;
    if (v2) begin
      m = model(2, {6'b0, a2}, {6'b0, b2}, c2);
      h2_s = m[1:0]; h2_c = m[8]; h2_o = m[9];
    end
    if (v8) begin
      m = model(8, a8, b8, c8);
      h8_s = m[7:0]; h8_c = m[8]; h8_o = m[9];
    end
    e.v2 = v2; e.s2 = h2_s; e.c2 = h2_c; e.o2 = h2_o;
    e.v8 = v8; e.s8 = h8_s; e.c8 = h8_c; e.o8 = h8_o;
    exp_q.push_back(e);
    tick();
    if (bif2.out_valid) pulses++;
    if (exp_q.size() == LAT) begin
      e = exp_q.pop_front();
      chk("s_n2_valid", 32'(bif2.out_valid), 32'(e.v2));
      chk("s_n2_res", {27'b0, bif2.OVF, bif2.Cout, bif2.SUM}, {27'b0, e.o2, e.c2, e.s2});
      chk("s_n8_valid", 32'(bif8.out_valid), 32'(e.v8));
      chk("s_n8_res", {22'b0, bif8.OVF, bif8.Cout, bif8.SUM}, {22'b0, e.o8, e.c8, e.s8});
    end
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{a: 2'd3, b: 2'd1, cin: 1'b0, sum: 2'd0, cout: 1'b1, ovf: 1'b0};
    tbl[1] = '{a: 2'd1, b: 2'd1, cin: 1'b0, sum: 2'd2, cout: 1'b0, ovf: 1'b1};
    tbl[2] = '{a: 2'd2, b: 2'd2, cin: 1'b0, sum: 2'd0, cout: 1'b1, ovf: 1'b1};
    tbl[3] = '{a: 2'd3, b: 2'd3, cin: 1'b1, sum: 2'd3, cout: 1'b1, ovf: 1'b0};
    tbl[4] = '{a: 2'd0, b: 2'd0, cin: 1'b0, sum: 2'd0, cout: 1'b0, ovf: 1'b0};
    tbl[5] = '{a: 2'd1, b: 2'd0, cin: 1'b1, sum: 2'd2, cout: 1'b0, ovf: 1'b1};
    tbl[6] = '{a: 2'd2, b: 2'd1, cin: 1'b1, sum: 2'd0, cout: 1'b1, ovf: 1'b0};
    tbl[7] = '{a: 2'd3, b: 2'd0, cin: 1'b1, sum: 2'd0, cout: 1'b1, ovf: 1'b0};

    // Reset state.
    rst_n = 1'b0;
    idle_all();
    tick();
    tick();
    chk("rst_n2", {28'b0, bif2.out_valid, bif2.OVF, bif2.Cout, |bif2.SUM}, 32'd0);
    chk("rst_n8", {28'b0, bif8.out_valid, bif8.OVF, bif8.Cout, |bif8.SUM}, 32'd0);

    // Operands presented on the very first edge with reset released.
    rst_n = 1'b1;
    bif2.in_valid = 1'b1; bif2.A = 2'd1; bif2.B = 2'd1; bif2.Cin = 1'b0;
    tick();
    bif2.in_valid = 1'b0;
    for (int k = 2; k <= LAT; k++) tick();
    chk("first_edge_valid", 32'(bif2.out_valid), 32'd1);
    chk("first_edge_res", {29'b0, bif2.OVF, bif2.SUM}, {29'b0, 1'b1, 2'd2});

    // Table vectors: latency, one-cycle pulse, hold afterwards.
    for (int i = 0; i < 8; i++) begin
      bif2.in_valid = 1'b1; bif2.A = tbl[i].a; bif2.B = tbl[i].b; bif2.Cin = tbl[i].cin;
      for (int k = 1; k <= LAT; k++) begin
        tick();
        bif2.in_valid = 1'b0; bif2.A = 2'd0; bif2.B = 2'd0; bif2.Cin = 1'b0;
        chk($sformatf("tbl%0d_valid_c%0d", i, k), 32'(bif2.out_valid), 32'(k == LAT));
      end
      chk($sformatf("tbl%0d_res", i), {28'b0, bif2.OVF, bif2.Cout, bif2.SUM},
          {28'b0, tbl[i].ovf, tbl[i].cout, tbl[i].sum});
      tick();
      chk($sformatf("tbl%0d_drop", i), 32'(bif2.out_valid), 32'd0);
    end

    // Hold: 2+1+1 accepted, then five idle cycles with zeroed operands.
    bif2.in_valid = 1'b1; bif2.A = 2'd2; bif2.B = 2'd1; bif2.Cin = 1'b1;
    tick();
    bif2.in_valid = 1'b0; bif2.A = 2'd0; bif2.B = 2'd0; bif2.Cin = 1'b0;
    for (int k = 2; k <= LAT; k++) tick();
    chk("hold_accept", {28'b0, bif2.out_valid, bif2.Cout, bif2.SUM}, {28'b0, 1'b1, 1'b1, 2'd0});
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("hold_c%0d", k), {27'b0, bif2.out_valid, bif2.OVF, bif2.Cout, bif2.SUM},
          {27'b0, 1'b0, 1'b0, 1'b1, 2'd0});
    end

    // Reset overriding an operation in flight; outputs start non-zero.
    bif2.in_valid = 1'b1; bif2.A = 2'd3; bif2.B = 2'd3; bif2.Cin = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    chk("rst_mid_clear", {27'b0, bif2.out_valid, bif2.OVF, bif2.Cout, bif2.SUM}, 32'd0);
    rst_n = 1'b1;
    bif2.in_valid = 1'b0; bif2.A = 2'd0; bif2.B = 2'd0; bif2.Cin = 1'b0;
    for (int k = 0; k <= LAT; k++) begin
      tick();
      chk($sformatf("rst_mid_quiet_c%0d", k),
          {27'b0, bif2.out_valid, bif2.OVF, bif2.Cout, bif2.SUM}, 32'd0);
    end

    // N=8 wrap: 255+1 with latency check.
    bif8.in_valid = 1'b1; bif8.A = 8'd255; bif8.B = 8'd1; bif8.Cin = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      bif8.in_valid = 1'b0; bif8.A = 8'd0; bif8.B = 8'd0;
      chk($sformatf("n8_wrap_valid_c%0d", k), 32'(bif8.out_valid), 32'(k == LAT));
    end
    chk("n8_wrap_res", {22'b0, bif8.OVF, bif8.Cout, bif8.SUM}, {22'b0, 1'b0, 1'b1, 8'd0});
    tick();
    chk("n8_wrap_drop", 32'(bif8.out_valid), 32'd0);

    // Streaming: restart from reset so the model hold state is known.
    rst_n = 1'b0;
    idle_all();
    tick();
    rst_n = 1'b1;
    h2_s = '0; h2_c = 1'b0; h2_o = 1'b0;
    h8_s = '0; h8_c = 1'b0; h8_o = 1'b0;
    exp_q.delete();
    pulses = 0;

    // Exhaustive N=2 back-to-back, with random N=8 traffic alongside.
    for (int i = 0; i < 32; i++) begin
      logic [4:0] iv;
      iv = 5'(i);
      step(1'b1, iv[4:3], iv[2:1], iv[0],
           1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
    end
    for (int k = 0; k < LAT; k++) step(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    chk("exhaustive_pulses", 32'(pulses), 32'd32);

    // Random valid/idle mix, results and holds scored against the model.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 2) != 0), 2'($urandom), 2'($urandom), 1'($urandom),
           1'($urandom_range(0, 2) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
    end
    for (int k = 0; k < LAT; k++) step(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
